// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Hazard-controller bundle. Carries pipeline hazard inputs
//               towards the controller and stage enables/flushes back.
//               Optional HAZARD_PERF_EN adds stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;
    logic        id_ex_MemRead;
    logic [4:0]  id_ex_rd;
    logic [4:0]  if_id_rs1;
    logic [4:0]  if_id_rs2;
    logic        if_id_use_rs1;
    logic        if_id_use_rs2;
    logic        branch_taken;
    logic        mem_busy;
    logic        PC_write;
    logic        IF_ID_write;
    logic        IF_flush;
    logic        ID_flush;
    logic        ID_EX_write;
    logic        EX_MEM_write;
    logic [1:0]  ctrl_state;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    // Pipeline side: supplies hazard information, consumes controls
    modport master (
        output id_ex_MemRead, id_ex_rd, if_id_rs1, if_id_rs2,
        output if_id_use_rs1, if_id_use_rs2, branch_taken, mem_busy,
        input  PC_write, IF_ID_write, IF_flush, ID_flush,
        input  ID_EX_write, EX_MEM_write, ctrl_state
`ifdef HAZARD_PERF_EN
        , input stall_cycles, flush_events
`endif
    );

    // Controller side
    modport slave (
        input  id_ex_MemRead, id_ex_rd, if_id_rs1, if_id_rs2,
        input  if_id_use_rs1, if_id_use_rs2, branch_taken, mem_busy,
        output PC_write, IF_ID_write, IF_flush, ID_flush,
        output ID_EX_write, EX_MEM_write, ctrl_state
`ifdef HAZARD_PERF_EN
        , output stall_cycles, flush_events
`endif
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : 5-stage pipeline sequencing controller. Inserts load-use
//               bubbles, runs the branch-redirect flush sequence and freezes
//               the pipeline while data memory is busy.
//               Optional macro HAZARD_PERF_EN adds stall_cycles and
//               flush_events performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int BRANCH_PENALTY = 2,
    parameter int CNT_W          = 4
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hc
);

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_REDIRECT = 2'd1;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd2;

    // Counter preload: REDIRECT lasts BRANCH_PENALTY-1 cycles after the branch cycle
    localparam logic [CNT_W-1:0] c_REDIR_INIT =
        CNT_W'((BRANCH_PENALTY > 1) ? (BRANCH_PENALTY - 2) : 0);

    logic [1:0]       r_state;
    logic [1:0]       r_resume;
    logic [CNT_W-1:0] r_redir_cnt;

    logic [1:0]       w_state_nxt;
    logic [1:0]       w_resume_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_eff_state;
    logic             w_load_use;
    logic             w_branch_accept;
    logic             w_pc_write;
    logic             w_if_id_write;
    logic             w_if_flush;
    logic             w_id_flush;
    logic             w_id_ex_write;
    logic             w_ex_mem_write;

    assign w_load_use = hc.id_ex_MemRead && (hc.id_ex_rd != 5'd0) &&
                        ((hc.if_id_use_rs1 && (hc.if_id_rs1 == hc.id_ex_rd)) ||
                         (hc.if_id_use_rs2 && (hc.if_id_rs2 == hc.id_ex_rd)));

    // Leaving MEM_WAIT costs no cycle: behave as the resumed state right away
    assign w_eff_state = ((r_state == c_ST_MEM_WAIT) && !hc.mem_busy) ? r_resume : r_state;

    // State, resume target and redirect counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_RUN;
            r_resume    <= c_ST_RUN;
            r_redir_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_resume    <= w_resume_nxt;
            r_redir_cnt <= w_cnt_nxt;
        end
    end

    // Next-state and Mealy control outputs; priority mem_busy > branch > load-use
    always_comb begin
        w_pc_write      = 1'b1;
        w_if_id_write   = 1'b1;
        w_if_flush      = 1'b0;
        w_id_flush      = 1'b0;
        w_id_ex_write   = 1'b1;
        w_ex_mem_write  = 1'b1;
        w_state_nxt     = w_eff_state;
        w_resume_nxt    = r_resume;
        w_cnt_nxt       = r_redir_cnt;
        w_branch_accept = 1'b0;
        if (rst) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            w_if_flush     = 1'b1;
            w_id_flush     = 1'b1;
        end else if (hc.mem_busy) begin
            // Freeze everything; pending branch/load-use stay in frozen registers
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            w_state_nxt    = c_ST_MEM_WAIT;
            if (r_state != c_ST_MEM_WAIT) begin
                w_resume_nxt = r_state;
            end
        end else begin
            case (w_eff_state)
                c_ST_RUN: begin
                    if (hc.branch_taken) begin
                        // Load-use in the same cycle is moot: its instruction is flushed
                        w_branch_accept = 1'b1;
                        w_if_flush      = 1'b1;
                        w_id_flush      = 1'b1;
                        if (BRANCH_PENALTY > 1) begin
                            w_state_nxt = c_ST_REDIRECT;
                            w_cnt_nxt   = c_REDIR_INIT;
                        end else begin
                            w_state_nxt = c_ST_RUN;
                        end
                    end else if (w_load_use) begin
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        w_id_flush    = 1'b1;
                        w_state_nxt   = c_ST_RUN;
                    end else begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
                c_ST_REDIRECT: begin
                    // Discard wrong-path fetches still returning from instruction memory
                    w_if_flush = 1'b1;
                    if (r_redir_cnt == '0) begin
                        w_state_nxt = c_ST_RUN;
                    end else begin
                        w_cnt_nxt   = r_redir_cnt - 1'b1;
                        w_state_nxt = c_ST_REDIRECT;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_RUN;
                end
            endcase
        end
    end

    assign hc.PC_write     = w_pc_write;
    assign hc.IF_ID_write  = w_if_id_write;
    assign hc.IF_flush     = w_if_flush;
    assign hc.ID_flush     = w_id_flush;
    assign hc.ID_EX_write  = w_id_ex_write;
    assign hc.EX_MEM_write = w_ex_mem_write;
    assign hc.ctrl_state   = r_state;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    // Performance counters: stalled cycles and accepted taken branches, wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!w_pc_write) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_branch_accept) begin
                r_flush_events <= r_flush_events + 32'd1;
            end
        end
    end

    assign hc.stall_cycles = r_stall_cycles;
    assign hc.flush_events = r_flush_events;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Drives one stimulus
//               table into two instances (BRANCH_PENALTY=2 and =1) and
//               compares against per-row expectations through a queue.
//               Counter checks are active when HAZARD_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam logic [5:0] c_D  = 6'b110011; // default
    localparam logic [5:0] c_R  = 6'b001100; // reset
    localparam logic [5:0] c_LU = 6'b000111; // load-use bubble
    localparam logic [5:0] c_B  = 6'b111111; // branch cycle
    localparam logic [5:0] c_RD = 6'b111011; // redirect cycle
    localparam logic [5:0] c_F  = 6'b000000; // freeze

    typedef struct {
        string      name;
        logic       rst;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic       busy;
        logic [5:0] c0;
        logic [1:0] s0;
        logic [5:0] c1;
        logic [1:0] s1;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs[$];
    vec_t sb[$];

    hazard_ctrl_if if0();
    hazard_ctrl_if if1();

    assign if1.id_ex_MemRead = if0.id_ex_MemRead;
    assign if1.id_ex_rd      = if0.id_ex_rd;
    assign if1.if_id_rs1     = if0.if_id_rs1;
    assign if1.if_id_rs2     = if0.if_id_rs2;
    assign if1.if_id_use_rs1 = if0.if_id_use_rs1;
    assign if1.if_id_use_rs2 = if0.if_id_use_rs2;
    assign if1.branch_taken  = if0.branch_taken;
    assign if1.mem_busy      = if0.mem_busy;

    hazard_ctrl #(.BRANCH_PENALTY(2), .CNT_W(4)) dut0 (.clk(clk), .rst(rst), .hc(if0.slave));
    hazard_ctrl #(.BRANCH_PENALTY(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .hc(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A taken branch can never be resolved while REDIRECT is flushing EX
    always @(negedge clk) begin
        assert (!(rst === 1'b0 && if0.ctrl_state == 2'd1 && if0.branch_taken === 1'b1))
            else $error("branch_taken asserted while in REDIRECT");
    end

    task automatic add(input string n, input logic r, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic br, input logic busy,
                       input logic [5:0] c0, input logic [1:0] s0,
                       input logic [5:0] c1, input logic [1:0] s1);
        vec_t v;
        v.name = n; v.rst = r; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1; v.u2 = u2; v.br = br; v.busy = busy;
        v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst               = v.rst;
        if0.id_ex_MemRead = v.mr;
        if0.id_ex_rd      = v.rd;
        if0.if_id_rs1     = v.rs1;
        if0.if_id_rs2     = v.rs2;
        if0.if_id_use_rs1 = v.u1;
        if0.if_id_use_rs2 = v.u2;
        if0.branch_taken  = v.br;
        if0.mem_busy      = v.busy;
    endtask

    task automatic check_vec(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", n, got, want);
        end
    endtask

    initial begin
        logic [5:0] ctl0;
        logic [5:0] ctl1;
        vec_t       e;
`ifdef HAZARD_PERF_EN
        logic [31:0] m_stall;
        logic [31:0] m_flush;
        m_stall = '0;
        m_flush = '0;
`endif
        checks   = 0;
        failures = 0;

        //    name          rst mr rd  rs1 rs2 u1 u2 br bsy  c0    s0  c1    s1
        add("reset",        1, 0, 0,  0,  0,  0, 0, 0, 0,  c_R,  0, c_R,  0);
        add("idle",         0, 0, 0,  0,  0,  0, 0, 0, 0,  c_D,  0, c_D,  0);
        add("lu_rs2",       0, 1, 5,  1,  5,  0, 1, 0, 0,  c_LU, 0, c_LU, 0);
        add("lu_bubble",    0, 0, 5,  1,  5,  0, 1, 0, 0,  c_D,  0, c_D,  0);
        add("x0_no_stall",  0, 1, 0,  0,  0,  1, 1, 0, 0,  c_D,  0, c_D,  0);
        add("unused_rs1",   0, 1, 7,  7,  3,  0, 1, 0, 0,  c_D,  0, c_D,  0);
        add("lu_rs1",       0, 1, 7,  7,  3,  1, 0, 0, 0,  c_LU, 0, c_LU, 0);
        add("no_memread",   0, 0, 7,  7,  7,  1, 1, 0, 0,  c_D,  0, c_D,  0);
        add("br_over_lu",   0, 1, 5,  5,  0,  1, 0, 1, 0,  c_B,  0, c_B,  0);
        add("redir_lu_ign", 0, 1, 5,  5,  0,  1, 0, 0, 0,  c_RD, 1, c_LU, 0);
        add("after_redir",  0, 0, 0,  0,  0,  0, 0, 0, 0,  c_D,  0, c_D,  0);
        add("br2",          0, 0, 0,  0,  0,  0, 0, 1, 0,  c_B,  0, c_B,  0);
        add("frz_redir1",   0, 0, 0,  0,  0,  0, 0, 0, 1,  c_F,  1, c_F,  0);
        add("frz_redir2",   0, 0, 0,  0,  0,  0, 0, 0, 1,  c_F,  2, c_F,  2);
        add("frz_redir3",   0, 0, 0,  0,  0,  0, 0, 0, 1,  c_F,  2, c_F,  2);
        add("frz_release",  0, 0, 0,  0,  0,  0, 0, 0, 0,  c_RD, 2, c_D,  2);
        add("frz_run",      0, 0, 0,  0,  0,  0, 0, 0, 0,  c_D,  0, c_D,  0);
        add("busy_br1",     0, 0, 0,  0,  0,  0, 0, 1, 1,  c_F,  0, c_F,  0);
        add("busy_br2",     0, 0, 0,  0,  0,  0, 0, 1, 1,  c_F,  2, c_F,  2);
        add("busy_br_rel",  0, 0, 0,  0,  0,  0, 0, 1, 0,  c_B,  2, c_B,  2);
        add("busy_br_rd",   0, 0, 0,  0,  0,  0, 0, 0, 0,  c_RD, 1, c_D,  0);
        add("busy_br_run",  0, 0, 0,  0,  0,  0, 0, 0, 0,  c_D,  0, c_D,  0);
        add("busy_lu",      0, 1, 9,  9,  0,  1, 0, 0, 1,  c_F,  0, c_F,  0);
        add("busy_lu_rel",  0, 1, 9,  9,  0,  1, 0, 0, 0,  c_LU, 2, c_LU, 2);
        add("busy_lu_done", 0, 0, 9,  9,  0,  1, 0, 0, 0,  c_D,  0, c_D,  0);
        add("br3",          0, 0, 0,  0,  0,  0, 0, 1, 0,  c_B,  0, c_B,  0);
        add("rst_mid_rd",   1, 0, 0,  0,  0,  0, 0, 0, 0,  c_R,  1, c_R,  0);
        add("post_rst",     0, 0, 0,  0,  0,  0, 0, 0, 0,  c_D,  0, c_D,  0);

        // Power-up reset before the table so state is known
        drive(vecs[0]);
        @(posedge clk); #1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            @(negedge clk);
            e    = sb.pop_front();
            ctl0 = {if0.PC_write, if0.IF_ID_write, if0.IF_flush, if0.ID_flush,
                    if0.ID_EX_write, if0.EX_MEM_write};
            ctl1 = {if1.PC_write, if1.IF_ID_write, if1.IF_flush, if1.ID_flush,
                    if1.ID_EX_write, if1.EX_MEM_write};
            check_vec({e.name, "/p2_ctl"},   32'(ctl0), 32'(e.c0));
            check_vec({e.name, "/p2_state"}, 32'(if0.ctrl_state), 32'(e.s0));
            check_vec({e.name, "/p1_ctl"},   32'(ctl1), 32'(e.c1));
            check_vec({e.name, "/p1_state"}, 32'(if1.ctrl_state), 32'(e.s1));
`ifdef HAZARD_PERF_EN
            check_vec({e.name, "/stall_cycles"}, if0.stall_cycles, m_stall);
            check_vec({e.name, "/flush_events"}, if0.flush_events, m_flush);
            if (e.rst) begin
                m_stall = '0;
                m_flush = '0;
            end else begin
                if (!e.c0[5]) m_stall = m_stall + 32'd1;
                if (e.c0 == c_B) m_flush = m_flush + 32'd1;
            end
`endif
            @(posedge clk); #1;
        end

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It generates write-enables and flushes for PC, IF/ID, ID/EX and EX/MEM.
- Inserts load-use bubbles through ID_flush.
- Runs a multi-cycle branch-redirect sequence that discards wrong-path fetches from a latent instruction memory.
- Freezes the whole pipeline while data memory is busy.

Parameters:
BRANCH_PENALTY, 2, cycles IF/ID is flushed after a taken branch (legal 1..15)
CNT_W, 4, width of redirect counter (must hold BRANCH_PENALTY-1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_ex_MemRead  in  1  ID/EX.MemRead
id_ex_rd  in  5  ID/EX.rd
if_id_rs1  in  5  IF/ID rs1
if_id_rs2  in  5  IF/ID rs2
if_id_use_rs1  in  1  instruction in ID reads rs1
if_id_use_rs2  in  1  instruction in ID reads rs2
branch_taken  in  1  EX resolved taken branch/jump
mem_busy  in  1  data memory not ready this cycle
PC_write  out  1  PC update enable
IF_ID_write  out  1  IF/ID enable
IF_flush  out  1  zero IF/ID on next edge
ID_flush  out  1  zero ID/EX on next edge (drives ID/EX ID_flush)
ID_EX_write  out  1  ID/EX enable
EX_MEM_write  out  1  EX/MEM and MEM/WB enable
ctrl_state  out  2  0=RUN 1=REDIRECT 2=MEM_WAIT

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Registered state: state, resume (RUN/REDIRECT), redir_cnt. All control outputs are combinational (Mealy) from state and inputs.
- While rst=1:
  - Enables PC_write, IF_ID_write, ID_EX_write and EX_MEM_write are 0.
  - IF_flush=1, ID_flush=1.
  - On the edge: state=RUN, resume=RUN, redir_cnt=0.
- Load-use hazard: load_use = id_ex_MemRead & (id_ex_rd!=0) & ((if_id_use_rs1 & if_id_rs1==id_ex_rd) | (if_id_use_rs2 & if_id_rs2==id_ex_rd)).
- Default (no event): all enables=1, flushes=0.
- Effective state: MEM_WAIT with mem_busy=0 is evaluated exactly as state resume in the same cycle (zero-cycle exit).
- Priority in every state: mem_busy > branch_taken > load_use.
- Freeze (mem_busy=1, any state):
  - All enables=0 and both flushes=0.
  - resume is set to RUN or REDIRECT (MEM_WAIT keeps its resume).
  - redir_cnt holds; next state=MEM_WAIT.
  - Pending branch_taken and load_use are held by the frozen registers and acted on after release.
- RUN, branch_taken=1:
  - PC_write=1 (loads target), IF_flush=1, ID_flush=1, ID_EX_write=1, EX_MEM_write=1, IF_ID_write=1.
  - If BRANCH_PENALTY>1: next=REDIRECT, redir_cnt=BRANCH_PENALTY-2. Otherwise stay RUN.
  - A load_use in the same cycle is ignored, since its instruction is flushed.
- RUN, load_use=1 (no branch):
  - PC_write=0, IF_ID_write=0, ID_flush=1, ID_EX_write=1, EX_MEM_write=1.
  - Stay RUN; exactly one bubble per hazard.
- REDIRECT:
  - IF_flush=1 and all enables=1; ID_flush=0; load_use is ignored.
  - redir_cnt decrements; when redir_cnt==0, next=RUN.
  - branch_taken in REDIRECT cannot occur (EX holds a bubble). It is ignored and flagged by a bench assertion.
- Reset mid-REDIRECT or mid-MEM_WAIT returns to RUN with the counter cleared; no flush sequence is replayed.
- id_ex_rd==0 never causes a stall.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds 32-bit outputs stall_cycles and flush_events, both cleared by rst:
  - stall_cycles increments on every cycle with PC_write=0 and rst=0 (load-use and freeze).
  - flush_events increments once per accepted taken branch.
  - Both wrap at 2^32.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Load-use: id_ex_MemRead=1, id_ex_rd=5, if_id_rs2=5, use_rs2=1 -> one cycle PC_write=0, IF_ID_write=0, ID_flush=1; next cycle (ID/EX bubble) all enables=1, flushes=0.
- x0 and unused operand: id_ex_rd=0 matching rs1, or rs1 match with use_rs1=0 -> no stall, outputs default.
- Branch, BRANCH_PENALTY=2: branch_taken at cycle t -> IF_flush=1 and ID_flush=1 at t; IF_flush=1 and ID_flush=0 at t+1; ctrl_state=0 at t+2. With BRANCH_PENALTY=1, only cycle t is flushed.
- Freeze during REDIRECT: mem_busy=1 for 3 cycles at t+1 -> all enables=0, ctrl_state=2 for 3 cycles; after release, one REDIRECT cycle with IF_flush=1, then RUN.
- Simultaneous mem_busy=1 and branch_taken=1 -> freeze with no flush; branch is redirected in the first cycle after mem_busy drops.
- Reset mid-REDIRECT: rst=1 for 1 cycle -> enables=0 and flushes=1 during reset; RUN next cycle; with HAZARD_PERF_EN, counters read 0.
